// File: rtl/sram_access_ctrl.sv
// Purpose: multi-cycle bridge from a core memory port to a synchronous SRAM macro.
// Latency: LATENCY+2 cycles from req to the next IDLE; stall is high for LATENCY+1 of them.
// Backpressure: stall is high combinationally with req in IDLE, held high through BUSY, and low for one DONE cycle.
module sram_access_ctrl #(
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = 32,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 read,
  input  logic [3:0]           web,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 stall,
  output logic                 sram_cs,
  output logic                 sram_oe,
  output logic [3:0]           sram_web,
  output logic [ADDR_BITS-1:0] sram_a,
  output logic [DATA_BITS-1:0] sram_di,
  input  logic [DATA_BITS-1:0] sram_do
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 read_q, read_d;
  logic [3:0]           web_q, web_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  assign rdata = rdata_q;

  // Next-state and SRAM pin decode; pins are driven only from captured registers so they stay stable in BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    web_d    = web_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'hF;
    sram_a   = '0;
    sram_di  = '0;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          read_d  = read;
          // A read must never write, whatever mask the core left on the bus.
          web_d   = read ? 4'hF : web;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        sram_cs  = 1'b1;
        sram_oe  = read_q;
        sram_web = web_q;
        sram_a   = addr_q;
        sram_di  = wdata_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (read_q) begin
            rdata_d = sram_do;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // One unstalled cycle lets the core advance; req is deliberately ignored here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset that aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      web_q   <= 4'h0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      web_q   <= web_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: main instance at LATENCY=2 with a byte-lane SRAM model,
// plus LATENCY=1 and LATENCY=4 instances for stall-length checks.
module tb_sram_access_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, read;
  logic [3:0]  web;
  logic [13:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata, sram_di, sram_do;
  logic        stall, sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;

  logic        req1, stall1, cs1, oe1;
  logic [3:0]  web1;
  logic [13:0] a1;
  logic [31:0] rdata1, di1, do1;
  logic        req4, stall4, cs4, oe4;
  logic [3:0]  web4;
  logic [13:0] a4;
  logic [31:0] rdata4, di4, do4;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  sram_access_ctrl #(.ADDR_BITS(14), .DATA_BITS(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .read(read), .web(web), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  sram_access_ctrl #(.ADDR_BITS(14), .DATA_BITS(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .read(read), .web(web), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .stall(stall1), .sram_cs(cs1), .sram_oe(oe1), .sram_web(web1),
    .sram_a(a1), .sram_di(di1), .sram_do(do1)
  );

  sram_access_ctrl #(.ADDR_BITS(14), .DATA_BITS(32), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .read(read), .web(web), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .stall(stall4), .sram_cs(cs4), .sram_oe(oe4), .sram_web(web4),
    .sram_a(a4), .sram_di(di4), .sram_do(do4)
  );

  // SRAM model: data is valid only from the LAT-th consecutive selected cycle, and a
  // write commits on the edge that ends that cycle, so an aborted access writes nothing.
  logic [31:0] mem [0:16383];
  int acc_cnt = 0;

  assign sram_do = (sram_cs && sram_oe && acc_cnt >= LAT - 1) ? mem[sram_a] : 32'hBAD0BAD0;
  assign do1 = (cs1 && oe1) ? 32'h11110001 : 32'h0;
  assign do4 = (cs4 && oe4) ? 32'h44440004 : 32'h0;

  always @(posedge clk) begin
    if (sram_cs) acc_cnt <= acc_cnt + 1;
    else         acc_cnt <= 0;
  end

  always @(posedge clk) begin
    if (sram_cs && acc_cnt == LAT - 1) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_web[b]) mem[sram_a][8*b +: 8] = sram_di[8*b +: 8];
      end
    end
  end

  // Follows stall from the current cycle until it drops, recording pins of the first
  // selected cycle and whether later selected cycles matched it.
  task automatic run_to_done(output int n_stall, output int n_cs, output logic [13:0] a_s,
                             output logic oe_s, output logic [3:0] web_s, output logic [31:0] di_s,
                             output logic stable);
    n_stall = 0; n_cs = 0; stable = 1'b1;
    a_s = '0; oe_s = 1'b0; web_s = '0; di_s = '0;
    while (stall === 1'b1 && n_stall < 40) begin
      n_stall++;
      if (sram_cs === 1'b1) begin
        if (n_cs == 0) begin
          a_s = sram_a; oe_s = sram_oe; web_s = sram_web; di_s = sram_di;
        end else if (sram_a !== a_s || sram_oe !== oe_s || sram_web !== web_s || sram_di !== di_s) begin
          stable = 1'b0;
        end
        n_cs++;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; read = 1'b0; web = 4'h0; addr = 14'h0123; wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", rdata, 32'h0); end
    total++; if (sram_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want=0", sram_cs); end
    total++; if (sram_web !== 4'hF) begin bad++; $display("FAIL reset_web got=%h want=f", sram_web); end
    total++; if (sram_oe !== 1'b0 || sram_a !== 14'h0 || sram_di !== 32'h0) begin
      bad++; $display("FAIL reset_pins got oe=%b a=%h di=%h want 0/0/0", sram_oe, sram_a, sram_di); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_follows_req got=%b want=1", stall); end
    req = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall_low got=%b want=0", stall); end
  endtask

  task automatic test_read;
    int ns, nc; logic [13:0] a_s; logic oe_s, st; logic [3:0] w_s; logic [31:0] d_s;
    @(negedge clk);
    req = 1'b1; read = 1'b1; web = 4'h0; addr = 14'h0010; wdata = 32'h55555555;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    run_to_done(ns, nc, a_s, oe_s, w_s, d_s, st);
    req = 1'b0;
    total++; if (ns !== LAT + 1) begin bad++; $display("FAIL read_stall_len got=%0d want=%0d", ns, LAT + 1); end
    total++; if (nc !== LAT || a_s !== 14'h0010 || oe_s !== 1'b1 || st !== 1'b1) begin
      bad++; $display("FAIL read_pins got cs_cycles=%0d a=%h oe=%b stable=%b want %0d/0010/1/1", nc, a_s, oe_s, st, LAT); end
    total++; if (w_s !== 4'hF) begin bad++; $display("FAIL read_web_forced got=%h want=f", w_s); end
    total++; if (sram_cs !== 1'b0 || sram_oe !== 1'b0 || sram_web !== 4'hF) begin
      bad++; $display("FAIL done_pins got cs=%b oe=%b web=%h want 0/0/f", sram_cs, sram_oe, sram_web); end
    exp_v = exp_q.pop_front();
    total++; if (rdata !== exp_v) begin bad++; $display("FAIL read_rdata got=%h want=%h", rdata, exp_v); end
  endtask

  task automatic test_byte_write;
    int ns, nc; logic [13:0] a_s; logic oe_s, st; logic [3:0] w_s; logic [31:0] d_s;
    @(negedge clk);
    req = 1'b1; read = 1'b0; web = 4'b1101; addr = 14'h0004; wdata = 32'h0000AB00;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    run_to_done(ns, nc, a_s, oe_s, w_s, d_s, st);
    req = 1'b0;
    total++; if (ns !== LAT + 1) begin bad++; $display("FAIL wr_stall_len got=%0d want=%0d", ns, LAT + 1); end
    total++; if (nc !== LAT || w_s !== 4'b1101 || oe_s !== 1'b0 || a_s !== 14'h0004 || d_s !== 32'h0000AB00 || st !== 1'b1) begin
      bad++; $display("FAIL wr_pins got cs_cycles=%0d web=%b oe=%b a=%h di=%h stable=%b", nc, w_s, oe_s, a_s, d_s, st); end
    total++; if (mem[4] !== 32'hC0DEAB04) begin bad++; $display("FAIL wr_mem_byte got=%h want=%h", mem[4], 32'hC0DEAB04); end
    exp_v = exp_q.pop_front();
    total++; if (rdata !== exp_v) begin bad++; $display("FAIL wr_rdata_kept got=%h want=%h", rdata, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat;
    @(negedge clk);
    req = 1'b1; read = 1'b0; web = 4'h0; addr = 14'h0008; wdata = 32'hCAFEF00D;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hCAFEF00D);
    for (int i = 0; i < 8; i++) begin
      #1;
      pat[7-i] = stall;
      if (i == 3) begin
        exp_v = exp_q.pop_front();
        total++; if (rdata !== exp_v) begin bad++; $display("FAIL b2b_wr_rdata got=%h want=%h", rdata, exp_v); end
        total++; if (mem[8] !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_mem got=%h want=%h", mem[8], 32'hCAFEF00D); end
        read = 1'b1; wdata = 32'h0;
      end
      if (i == 7) begin
        exp_v = exp_q.pop_front();
        total++; if (rdata !== exp_v) begin bad++; $display("FAIL b2b_rd_rdata got=%h want=%h", rdata, exp_v); end
        req = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (pat !== 8'b11101110) begin bad++; $display("FAIL b2b_stall_pattern got=%b want=%b", pat, 8'b11101110); end
  endtask

  task automatic test_input_change;
    int ns, nc; logic [13:0] a_s; logic oe_s, st; logic [3:0] w_s; logic [31:0] d_s;
    @(negedge clk);
    req = 1'b1; read = 1'b1; web = 4'hF; addr = 14'h0020; wdata = 32'h0;
    exp_q.push_back(32'hC0DE0020);
    @(negedge clk); #1;
    addr = 14'h3FFF; read = 1'b0; web = 4'h0; wdata = 32'hFFFFFFFF;
    run_to_done(ns, nc, a_s, oe_s, w_s, d_s, st);
    req = 1'b0;
    total++; if (ns !== LAT || nc !== LAT || st !== 1'b1) begin
      bad++; $display("FAIL chg_timing got stall=%0d cs=%0d stable=%b want %0d/%0d/1", ns, nc, st, LAT, LAT); end
    total++; if (a_s !== 14'h0020 || w_s !== 4'hF || oe_s !== 1'b1) begin
      bad++; $display("FAIL chg_pins got a=%h web=%h oe=%b want 0020/f/1", a_s, w_s, oe_s); end
    exp_v = exp_q.pop_front();
    total++; if (rdata !== exp_v) begin bad++; $display("FAIL chg_rdata got=%h want=%h", rdata, exp_v); end
    total++; if (mem[14'h3FFF] !== 32'hC0DE3FFF) begin bad++; $display("FAIL chg_no_write got=%h want=%h", mem[14'h3FFF], 32'hC0DE3FFF); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    req = 1'b1; read = 1'b0; web = 4'h0; addr = 14'h0030; wdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    total++; if (sram_cs !== 1'b1 || sram_web !== 4'h0) begin
      bad++; $display("FAIL abort_busy got cs=%b web=%h want 1/0", sram_cs, sram_web); end
    rst = 1'b1; req = 1'b0;
    @(negedge clk); #1;
    total++; if (sram_cs !== 1'b0 || sram_web !== 4'hF || stall !== 1'b0) begin
      bad++; $display("FAIL abort_pins got cs=%b web=%h stall=%b want 0/f/0", sram_cs, sram_web, stall); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h want=0", rdata); end
    total++; if (mem[14'h0030] !== 32'hC0DE0030) begin bad++; $display("FAIL abort_mem got=%h want=%h", mem[14'h0030], 32'hC0DE0030); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (mem[14'h0030] !== 32'hC0DE0030 || sram_cs !== 1'b0) begin
      bad++; $display("FAIL abort_mem_later got=%h cs=%b want=%h/0", mem[14'h0030], sram_cs, 32'hC0DE0030); end
  endtask

  task automatic test_latency_variants;
    int n1, n4; logic d1, d4;
    @(negedge clk);
    read = 1'b1; web = 4'hF; addr = 14'h0010; req1 = 1'b1; req4 = 1'b1;
    n1 = 0; n4 = 0; d1 = 1'b0; d4 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (!d1) begin if (stall1 === 1'b1) n1++; else begin d1 = 1'b1; req1 = 1'b0; end end
      if (!d4) begin if (stall4 === 1'b1) n4++; else begin d4 = 1'b1; req4 = 1'b0; end end
      @(negedge clk);
    end
    req1 = 1'b0; req4 = 1'b0;
    total++; if (n1 !== 2) begin bad++; $display("FAIL lat1_stall_len got=%0d want=2", n1); end
    total++; if (n4 !== 5) begin bad++; $display("FAIL lat4_stall_len got=%0d want=5", n4); end
    total++; if (rdata1 !== 32'h11110001 || rdata4 !== 32'h44440004) begin
      bad++; $display("FAIL lat_rdata got=%h/%h want=11110001/44440004", rdata1, rdata4); end
    total++; if (cs1 !== 1'b0 || cs4 !== 1'b0 || web1 !== 4'hF || web4 !== 4'hF || a1 !== 14'h0 || a4 !== 14'h0 || di1 !== 32'h0 || di4 !== 32'h0) begin
      bad++; $display("FAIL lat_idle_pins got cs=%b%b web=%h%h", cs1, cs4, web1, web4); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[16] = 32'hDEADBEEF;
    rst = 1'b1; req = 1'b0; read = 1'b0; web = 4'hF; addr = '0; wdata = '0;
    req1 = 1'b0; req4 = 1'b0;
    test_reset();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_input_change();
    test_reset_mid_access();
    test_latency_variants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
